// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and datapath controls between the multicycle controller and its datapath.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite;
   logic       AddrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;
   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AddrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
   );
   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AddrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing RV32I instructions through the multicycle datapath.
module multicycle_controller (
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
      EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
   } state_t;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   state_t     st, nx;
   logic [1:0] alu_op;
   logic       branch, pc_update, ir_write, reg_write, mem_write, sub_op;
   always_ff @(posedge clk or negedge reset)
      if (!reset) st <= FETCH;
      else        st <= nx;
   always_comb begin
      nx            = FETCH;
      alu_op        = 2'b00;
      branch        = 1'b0;
      pc_update     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      bus.AddrSrc   = 1'b0;
      bus.ResultSrc = 2'b00;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      case (st)
         FETCH: begin
            nx            = DECODE;
            ir_write      = 1'b1;
            pc_update     = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         DECODE: begin
            nx = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                 bus.op == OP_R   ? EXECR :
                 bus.op == OP_I   ? EXECI :
                 bus.op == OP_BEQ ? BEQ   :
                 bus.op == OP_JAL ? JAL   : FETCH;
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
         end
         MEMADR: begin
            nx          = bus.op == OP_LW ? MEMREAD : MEMWRITE;
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         MEMREAD: begin
            nx          = MEMWB;
            bus.AddrSrc = 1'b1;
         end
         MEMWB: begin
            reg_write     = 1'b1;
            bus.ResultSrc = 2'b01;
         end
         MEMWRITE: begin
            mem_write   = 1'b1;
            bus.AddrSrc = 1'b1;
         end
         EXECR: begin
            nx          = ALUWB;
            alu_op      = 2'b10;
            bus.ALUSrcA = 2'b10;
         end
         EXECI: begin
            nx          = ALUWB;
            alu_op      = 2'b10;
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         ALUWB: reg_write = 1'b1;
         BEQ: begin
            alu_op      = 2'b01;
            branch      = 1'b1;
            bus.ALUSrcA = 2'b10;
         end
         JAL: begin
            nx          = ALUWB;
            pc_update   = 1'b1;
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
         end
         default: nx = FETCH;
      endcase
   end
   // Write enables are gated by reset so nothing commits while it is held low.
   assign bus.PCWrite  = reset & (pc_update | (branch & bus.zero));
   assign bus.IRWrite  = reset & ir_write;
   assign bus.RegWrite = reset & reg_write;
   assign bus.MemWrite = reset & mem_write;
   assign bus.state    = st;
   assign sub_op       = bus.funct7b5 & bus.op[5];
   always_comb
      bus.ImmSrc = bus.op == OP_SW  ? 2'b01 :
                   bus.op == OP_BEQ ? 2'b10 :
                   bus.op == OP_JAL ? 2'b11 : 2'b00;
   always_comb
      bus.ALUControl = alu_op == 2'b01         ? 3'b001 :
                       alu_op != 2'b10         ? 3'b000 :
                       bus.funct3 == 3'b000    ? {2'b00, sub_op} :
                       bus.funct3 == 3'b010    ? 3'b101 :
                       bus.funct3 == 3'b110    ? 3'b011 :
                       bus.funct3 == 3'b111    ? 3'b010 : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream against a per-cycle scoreboard of expected control words.
module tb_multicycle_controller;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw, addr, memw, irw, regw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   multicycle_controller_if bus();
   multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   function automatic logic [2:0] alu_of(logic [1:0] aop, logic [6:0] o, logic [2:0] f3, logic f7);
      if (aop == 2'b01) return 3'b001;
      if (aop != 2'b10) return 3'b000;
      case (f3)
         3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction
   // Expected control word for one cycle spent in state s.
   function automatic exp_t exp_of(int s, logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic rst);
      exp_t       e = '0;
      logic [1:0] aop = 2'b00;
      logic       pcu = 1'b0;
      logic       br = 1'b0;
      e.st  = 4'(s);
      e.imm = o == OP_SW ? 2'd1 : o == OP_BEQ ? 2'd2 : o == OP_JAL ? 2'd3 : 2'd0;
      case (s)
         0:  begin e.irw = 1; e.sb = 2; e.rs = 2; pcu = 1; end
         1:  begin e.sa = 1; e.sb = 1; end
         2:  begin e.sa = 2; e.sb = 1; end
         3:  e.addr = 1;
         4:  begin e.rs = 1; e.regw = 1; end
         5:  begin e.addr = 1; e.memw = 1; end
         6:  begin e.sa = 2; aop = 2; end
         7:  begin e.sa = 2; e.sb = 1; aop = 2; end
         8:  e.regw = 1;
         9:  begin e.sa = 2; aop = 1; br = 1; end
         10: begin e.sa = 1; e.sb = 2; pcu = 1; end
         default: ;
      endcase
      e.pcw = pcu | (br & z);
      e.alu = alu_of(aop, o, f3, f7);
      if (rst) begin
         e.pcw = 0; e.irw = 0; e.regw = 0; e.memw = 0;
      end
      return e;
   endfunction
   task automatic do_reset(input int k);
      reset = 1'b0;
      for (int i = 0; i < k; i++) begin
         bus.zero = 1'($urandom);
         q.push_back(exp_of(0, bus.op, bus.funct3, bus.funct7b5, bus.zero, 1'b1));
         @(posedge clk); #1;
      end
      reset = 1'b1;
   endtask
   // Runs the first n cycles of an instruction; a shorter n aborts it with a reset.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic zb, input int n);
      int path[$];
      case (o)
         OP_LW:   path = '{0, 1, 2, 3, 4};
         OP_SW:   path = '{0, 1, 2, 5};
         OP_R:    path = '{0, 1, 6, 8};
         OP_I:    path = '{0, 1, 7, 8};
         OP_BEQ:  path = '{0, 1, 9};
         OP_JAL:  path = '{0, 1, 10, 8};
         default: path = '{0, 1};
      endcase
      bus.op = o;
      bus.funct3 = f3;
      bus.funct7b5 = f7;
      for (int i = 0; i < path.size() && i < n; i++) begin
         bus.zero = (path[i] == 9) ? zb : 1'($urandom);
         q.push_back(exp_of(path[i], o, f3, f7, bus.zero, 1'b0));
         @(posedge clk); #1;
      end
      if (n < path.size()) do_reset(1 + int'($urandom_range(0, 2)));
   endtask
   always @(negedge clk)
      if (q.size() > 0) begin : mon
         exp_t e, a;
         e = q.pop_front();
         a = {bus.state, bus.PCWrite, bus.AddrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL ctrl t=%0t op=%b: got st=%0d pcw=%b addr=%b memw=%b irw=%b regw=%b rs=%b sa=%b sb=%b imm=%b alu=%b, want st=%0d pcw=%b addr=%b memw=%b irw=%b regw=%b rs=%b sa=%b sb=%b imm=%b alu=%b",
                     $time, bus.op, a.st, a.pcw, a.addr, a.memw, a.irw, a.regw, a.rs, a.sa, a.sb, a.imm, a.alu,
                     e.st, e.pcw, e.addr, e.memw, e.irw, e.regw, e.rs, e.sa, e.sb, e.imm, e.alu);
         end
      end
   initial begin
      logic [6:0] ops[6];
      logic [2:0] f3s[5];
      logic [6:0] o;
      ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
      f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b000};
      bus.op = 7'd0;
      bus.funct3 = 3'd0;
      bus.funct7b5 = 1'b0;
      bus.zero = 1'b0;
      @(posedge clk); #1;
      do_reset(3);
      run_instr(OP_LW, 3'b000, 1'b0, 1'b0, 99);
      run_instr(OP_SW, 3'b010, 1'b1, 1'b0, 99);
      run_instr(OP_R, 3'b000, 1'b1, 1'b0, 99);
      run_instr(OP_I, 3'b000, 1'b1, 1'b0, 99);
      run_instr(OP_R, 3'b010, 1'b0, 1'b0, 99);
      run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 99);
      run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 99);
      run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 99);
      run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 99);
      run_instr(OP_LW, 3'b000, 1'b0, 1'b0, 3);
      run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 3);
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            do o = 7'($urandom);
            while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL);
         end else o = ops[$urandom_range(0, 5)];
         run_instr(o, $urandom_range(0, 3) == 0 ? 3'($urandom) : f3s[$urandom_range(0, 4)],
                   1'($urandom), 1'($urandom),
                   $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 4)) : 99);
      end
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every select and write enable of the multicycle datapath plus the memory write strobe. Instruction fields arrive from the datapath's instruction register; the ALU `zero` flag returns from the datapath for branch resolution.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `op`  in  7  `Instr[6:0]`
- `funct3`  in  3  `Instr[14:12]`
- `funct7b5`  in  1  `Instr[30]`
- `zero`  in  1  ALU zero flag (combinational, same cycle)
- `PCWrite`  out  1  PC register enable
- `AddrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction/OldPC register enable
- `ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
- `ALUSrcA`  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = A
- `ALUSrcB`  out  2  SrcB select: 00 = WriteData, 01 = ImmExt, 10 = 4
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `RegWrite`  out  1  register file write enable
- `state`  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10. Encodings 11–15 → FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE decodes `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH; no write enable asserts.
  - MEMADR → MEMREAD if `op` = lw, else → MEMWRITE.
  - MEMREAD → MEMWB. EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Internal signals: `ALUOp` (2 bits), `Branch`, `PCUpdate`. Any signal not listed for a state is 0.
- Outputs per state:
  - FETCH: AddrSrc = 0, IRWrite = 1, SrcA = 00, SrcB = 10, ALUOp = 00, ResultSrc = 10, PCUpdate = 1.
  - DECODE: SrcA = 01, SrcB = 01, ALUOp = 00. ALUOut captures OldPC + imm as the branch/jump target.
  - MEMADR: SrcA = 10, SrcB = 01, ALUOp = 00.
  - MEMREAD: ResultSrc = 00, AddrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: ResultSrc = 00, AddrSrc = 1, MemWrite = 1.
  - EXECR: SrcA = 10, SrcB = 00, ALUOp = 10.
  - EXECI: SrcA = 10, SrcB = 01, ALUOp = 10.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - BEQ: SrcA = 10, SrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1.
  - JAL: SrcA = 01, SrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1.
- `PCWrite` = PCUpdate | (Branch & zero).
- `ImmSrc` is decoded from `op` in every state:
  - lw / 0010011 → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - any other opcode → 00
- ALU decoder:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 decodes `funct3`:
    - 000 → sub if `funct7b5` & `op[5]`, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other value → add
  - ALUOp 11 → add.

## Timing
- State register updates on the rising edge of `clk`.
- All outputs are combinational from `state` and the instruction fields. `PCWrite` additionally depends on `zero` in the same cycle (zero → PCWrite path).
- Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, unsupported opcode 2.
- Reset:
  - `reset` = 0 forces `state` = FETCH immediately, without waiting for a clock edge.
  - While `reset` is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The select outputs show FETCH values.
  - The first FETCH with enables asserted is the cycle after `reset` rises.
- Reset asserted mid-instruction aborts the instruction; no partial writes occur after assertion.
- `zero` is sampled only in BEQ. In every other state, `zero` has no effect on any output.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles in arbitrary state → `state` = 0 and all four write enables 0; release → FETCH shows IRWrite = 1, PCWrite = 1, ALUSrcB = 10.
- lw, `op` = 0000011 → states 0, 1, 2, 3, 4, 0; MEMREAD has AddrSrc = 1; MEMWB has ResultSrc = 01, RegWrite = 1; ImmSrc = 00 throughout.
- sw, `op` = 0100011 → states 0, 1, 2, 5, 0; MemWrite = 1 only in state 5; RegWrite is never 1; ImmSrc = 01.
- R-type sub, `op` = 0110011, funct3 = 000, funct7b5 = 1 → EXECR gives ALUControl = 001. Same fields with `op` = 0010011 → EXECI gives ALUControl = 000. funct3 = 010 → 101.
- beq: `zero` = 1 in BEQ → PCWrite = 1, ResultSrc = 00, ALUControl = 001. `zero` = 0 → PCWrite = 0. Both cases return to FETCH after 3 cycles.
- jal, `op` = 1101111 → states 0, 1, 10, 8, 0; state 10 has PCWrite = 1, ALUSrcA = 01, ALUSrcB = 10; ImmSrc = 11. Unsupported `op` = 0110111 → 0, 1, 0 with no write enables in DECODE.
